// File: rtl/uart_tx_engine_if.sv
// Parallel-word handshake between a producer and the UART transmit engine.
interface uart_tx_engine_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_valid_i;
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_ready_o;

    modport master (output tx_valid_i, output tx_data_i, input tx_ready_o);
    modport slave  (input tx_valid_i, input tx_data_i, output tx_ready_o);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bits,
// with every bit period delimited by baud_tick_i.
module uart_tx_engine #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              rst,
    input  logic              baud_tick_i,
    uart_tx_engine_if.slave   bus,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    // Next state; the counter counts data bits, then is reused for stop bits.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.tx_valid_i) begin
                    state_d = S_SYNC;
                    shift_d = bus.tx_data_i;
                    cnt_d   = '0;
                    par_d   = (^bus.tx_data_i) ^ (PARITY_ODD != 0);
                end
            end
            S_SYNC:   if (baud_tick_i) state_d = S_START;
            S_START:  if (baud_tick_i) state_d = S_DATA;
            S_DATA: begin
                if (baud_tick_i) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: if (baud_tick_i) state_d = S_STOP;
            S_STOP: begin
                if (baud_tick_i) begin
                    if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            state_d = S_IDLE;
            shift_d = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
            done_d  = 1'b0;
        end

        // Line level follows the state being entered so it is registered with it.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_ready_o = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign tx_o           = tx_q;
    assign done_o         = done_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench: four engine configurations share one stimulus stream and are
// compared each cycle against a frame-list reference model, plus directed frame checks.
module tb_uart_tx_engine;
    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    always #5 clk = ~clk;

    uart_tx_engine_if #(.DATA_BITS(8)) if0 ();
    uart_tx_engine_if #(.DATA_BITS(8)) if1 ();
    uart_tx_engine_if #(.DATA_BITS(8)) if2 ();
    uart_tx_engine_if #(.DATA_BITS(8)) if3 ();
    assign if0.tx_valid_i = valid;  assign if0.tx_data_i = data;
    assign if1.tx_valid_i = valid;  assign if1.tx_data_i = data;
    assign if2.tx_valid_i = valid;  assign if2.tx_data_i = data;
    assign if3.tx_valid_i = valid;  assign if3.tx_data_i = data;

    logic [3:0] d_tx, d_busy, d_done, d_ready;
    assign d_ready = {if3.tx_ready_o, if2.tx_ready_o, if1.tx_ready_o, if0.tx_ready_o};

    // 8N1, 8E1, 8N2, 8O1
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .arst(arst), .rst(rst), .baud_tick_i(tick), .bus(if0),
        .tx_o(d_tx[0]), .busy_o(d_busy[0]), .done_o(d_done[0]));
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .arst(arst), .rst(rst), .baud_tick_i(tick), .bus(if1),
        .tx_o(d_tx[1]), .busy_o(d_busy[1]), .done_o(d_done[1]));
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk(clk), .arst(arst), .rst(rst), .baud_tick_i(tick), .bus(if2),
        .tx_o(d_tx[2]), .busy_o(d_busy[2]), .done_o(d_done[2]));
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u3 (
        .clk(clk), .arst(arst), .rst(rst), .baud_tick_i(tick), .bus(if3),
        .tx_o(d_tx[3]), .busy_o(d_busy[3]), .done_o(d_done[3]));

    int total = 0;
    int bad   = 0;
    int pe[4];
    int po[4];
    int sb[4];

    // Reference: 0 idle, 1 waiting for first tick, 2 walking the frame bit list.
    int   m_st[4];
    logic m_bits[4][16];
    int   m_n[4];
    int   m_idx[4];
    logic m_done[4];

    logic tr_tx[4][64];
    logic tr_done[4][64];
    logic tr_ready[4][64];
    int   tc = 0;
    bit   tr_on = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       par_even;
        logic       par_odd;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s idx=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0;
            m_idx[i] = 0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic r, input logic tk, input logic v, input logic [7:0] d);
        for (int i = 0; i < 4; i++) begin
            m_done[i] = 1'b0;
            if (r) begin
                m_st[i] = 0;
            end else if (m_st[i] == 0) begin
                if (v) begin
                    m_n[i] = 0;
                    m_bits[i][m_n[i]] = 1'b0; m_n[i]++;
                    for (int b = 0; b < 8; b++) begin
                        m_bits[i][m_n[i]] = d[b]; m_n[i]++;
                    end
                    if (pe[i] != 0) begin
                        m_bits[i][m_n[i]] = (^d) ^ (po[i] != 0); m_n[i]++;
                    end
                    for (int s = 0; s < sb[i]; s++) begin
                        m_bits[i][m_n[i]] = 1'b1; m_n[i]++;
                    end
                    m_st[i] = 1;
                end
            end else if (m_st[i] == 1) begin
                if (tk) begin
                    m_st[i] = 2;
                    m_idx[i] = 0;
                end
            end else if (tk) begin
                m_idx[i]++;
                if (m_idx[i] == m_n[i]) begin
                    m_st[i] = 0;
                    m_done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic etx;
        for (int i = 0; i < 4; i++) begin
            etx = (m_st[i] == 2) ? m_bits[i][m_idx[i]] : 1'b1;
            chk("model{tx,busy,ready,done}", i, {d_tx[i], d_busy[i], d_ready[i], d_done[i]},
                {etx, m_st[i] != 0, m_st[i] == 0, m_done[i]});
        end
    endtask

    task automatic cyc(input logic tk, input logic v, input logic [7:0] d);
        tick = tk; valid = v; data = d;
        @(posedge clk);
        model_edge(rst || arst, tk, v, d);
        #1;
        check_model();
        if (tr_on && tc < 64) begin
            for (int i = 0; i < 4; i++) begin
                tr_tx[i][tc] = d_tx[i];
                tr_done[i][tc] = d_done[i];
                tr_ready[i][tc] = d_ready[i];
            end
        end
        tc++;
    endtask

    // vmode 0: single valid; 1: valid held with word d1; 2: valid and data random.
    task automatic run(input int period, input int vmode, input logic [7:0] d0,
                       input logic [7:0] d1, input int n);
        logic v;
        logic [7:0] d;
        tr_on = 1'b1; tc = 0;
        for (int c = 0; c < n; c++) begin
            if (c == 0) begin
                v = 1'b1; d = d0;
            end else if (vmode == 0) begin
                v = 1'b0; d = 8'($urandom);
            end else if (vmode == 1) begin
                v = 1'b1; d = d1;
            end else begin
                v = 1'($urandom); d = 8'($urandom);
            end
            cyc((c % period) == period - 1, v, d);
        end
        tr_on = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && d_ready != 4'hF; k++) cyc(1'b1, 1'b0, 8'h00);
        chk("drain_ready", 0, d_ready, 4'hF);
    endtask

    function automatic logic [7:0] grab(input int inst, input int off, input int stride);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = tr_tx[inst][off + stride * b];
        return v;
    endfunction

    function automatic int done_count(input int inst, input int n);
        int cnt = 0;
        for (int c = 0; c < n; c++) if (tr_done[inst][c]) cnt++;
        return cnt;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f1;
        logic       rdy_any;
        pe = '{0, 1, 0, 1};
        po = '{0, 0, 0, 1};
        sb = '{1, 1, 2, 1};
        tbl[0] = '{8'hA5, 1'b0, 1'b1};
        tbl[1] = '{8'h07, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 1'b0, 1'b1};
        tbl[4] = '{8'h01, 1'b1, 1'b0};
        tbl[5] = '{8'h3C, 1'b0, 1'b1};
        model_reset();

        #1 arst = 1'b1;
        #3;
        for (int i = 0; i < 4; i++) begin
            chk("rst_tx", i, d_tx[i], 1);
            chk("rst_busy", i, d_busy[i], 0);
            chk("rst_ready", i, d_ready[i], 1);
            chk("rst_done", i, d_done[i], 0);
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h55);
        arst = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);

        // 0xA5, tick every 4 cycles: sync, then ten 4-cycle bits, done once.
        run(4, 0, 8'hA5, 8'h00, 60);
        f1 = {1'b1, 8'hA5, 1'b0};
        for (int c = 0; c < 3; c++) chk("t1_sync", c, tr_tx[0][c], 1);
        for (int b = 0; b < 10; b++)
            chk("t1_bit", b, {tr_tx[0][3+4*b], tr_tx[0][4+4*b], tr_tx[0][5+4*b], tr_tx[0][6+4*b]},
                {4{f1[b]}});
        chk("t1_done_at", 43, tr_done[0][43], 1);
        chk("t1_done_cnt", 0, done_count(0, 60), 1);
        rdy_any = 1'b0;
        for (int c = 0; c < 43; c++) rdy_any |= tr_ready[0][c];
        chk("t1_ready_low", 0, rdy_any, 0);
        chk("t1_par_even", 1, tr_tx[1][39], 0);
        chk("t1_par_odd", 3, tr_tx[3][39], 1);
        drain();

        // Tick every cycle: parity table, 10-cycle frames, two stop bits on u2.
        foreach (tbl[k]) begin
            run(1, 0, tbl[k].d, 8'h00, 20);
            chk("tb_sync", k, tr_tx[0][0], 1);
            chk("tb_start", k, tr_tx[0][1], 0);
            chk("tb_data", k, grab(0, 2, 1), tbl[k].d);
            chk("tb_stop", k, tr_tx[0][10], 1);
            chk("tb_done_at", k, tr_done[0][11], 1);
            chk("tb_done_cnt", k, done_count(0, 20), 1);
            chk("tb_par_even", k, tr_tx[1][10], tbl[k].par_even);
            chk("tb_par_odd", k, tr_tx[3][10], tbl[k].par_odd);
            chk("tb_stop2", k, {tr_tx[2][10], tr_tx[2][11]}, 2'b11);
            chk("tb_done2_at", k, tr_done[2][12], 1);
            drain();
        end

        // Valid held high with a new word: re-accept right after done.
        run(1, 1, 8'h00, 8'h5A, 30);
        chk("b2b_ready_at_done", 2, {tr_done[2][12], tr_ready[2][12]}, 2'b11);
        chk("b2b_sync", 2, {tr_ready[2][13], tr_tx[2][13]}, 2'b01);
        chk("b2b_start", 2, tr_tx[2][14], 0);
        chk("b2b_data", 2, grab(2, 15, 1), 8'h5A);
        chk("b2b_u0_reaccept", 0, tr_ready[0][12], 0);
        drain();

        // Async reset during the third data bit of 0x3C.
        run(4, 0, 8'h3C, 8'h00, 16);
        chk("ar_pre_bits", 0, {tr_tx[0][7], tr_tx[0][11], tr_tx[0][15]}, 3'b001);
        arst = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("ar_tx", i, d_tx[i], 1);
            chk("ar_busy", i, d_busy[i], 0);
            chk("ar_done", i, d_done[i], 0);
        end
        model_reset();
        cyc(1'b1, 1'b0, 8'h00);
        arst = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        run(4, 0, 8'h3C, 8'h00, 50);
        chk("ar_resend", 0, grab(0, 7, 4), 8'h3C);
        chk("ar_resend_done", 0, done_count(0, 50), 1);
        drain();

        // Valid toggling and data changing mid-frame.
        run(4, 2, 8'h96, 8'h00, 60);
        chk("t6_data", 0, grab(0, 7, 4), 8'h96);
        chk("t6_par_even", 1, tr_tx[1][39], 0);
        chk("t6_par_odd", 3, tr_tx[3][39], 1);
        valid = 1'b0;
        drain();

        // Random traffic with varying tick density and occasional sync reset.
        for (int k = 0; k < 4000; k++) begin
            logic tk;
            if ((k / 500) % 3 == 0)      tk = 1'b1;
            else if ((k / 500) % 3 == 1) tk = ($urandom % 3) == 0;
            else                         tk = ($urandom % 7) == 0;
            rst = ($urandom % 250) == 0;
            cyc(tk, 1'($urandom), 8'($urandom));
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
